// File: rtl/iddmm_result_sel.sv
// Final-result selector for the IDDMM calculation stage: buffers the raw and
// reduced result streams, then drains the chosen one over valid/ready, LSW first.
module iddmm_result_sel #(
    parameter int unsigned K      = 128,
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_wr_en_a,
    input  logic [K-1:0]      fifo_wr_data_a,
    input  logic              fifo_wr_en_sub,
    input  logic [K-1:0]      fifo_wr_data_sub,
    input  logic              cal_done,
    input  logic              cal_sign,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [K-1:0]      o_data,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_last,
    output logic              o_sel_sub,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt_a, cnt_a_nxt;
    logic [CNT_W-1:0]   cnt_sub, cnt_sub_nxt;
    logic               done_l, done_l_nxt;
    logic               err_nxt;
    logic               sel_nxt;
    logic               valid_nxt;
    logic [ADDR_W-1:0]  idx_nxt;
    logic [K-1:0]       data_nxt;
    logic               wr_a_c;
    logic               wr_sub_c;
    logic [ADDR_W-1:0]  rd_idx_c;
    logic [K-1:0]       rd_word_c;
    logic               full_c;
    logic               last_idx_c;

    logic [K-1:0] buf_a   [N];
    logic [K-1:0] buf_sub [N];

    // Next word to present: word 0 when launching a drain, otherwise the successor.
    assign rd_idx_c   = (state == COLLECT) ? '0 : ADDR_W'(o_idx + ADDR_W'(1));
    assign rd_word_c  = o_sel_sub ? buf_sub[rd_idx_c] : buf_a[rd_idx_c];
    assign full_c     = (cnt_a == CNT_W'(N)) && (cnt_sub == CNT_W'(N));
    assign last_idx_c = (o_idx == ADDR_W'(N - 1));

    assign o_last = o_valid && last_idx_c;
    assign busy   = done_l || (state == DRAIN);

    // Next-state and register-update decode.
    always_comb begin
        state_nxt   = state;
        cnt_a_nxt   = cnt_a;
        cnt_sub_nxt = cnt_sub;
        done_l_nxt  = done_l;
        err_nxt     = err;
        sel_nxt     = o_sel_sub;
        valid_nxt   = o_valid;
        idx_nxt     = o_idx;
        data_nxt    = o_data;
        wr_a_c      = 1'b0;
        wr_sub_c    = 1'b0;

        case (state)
            COLLECT: begin
                if (fifo_wr_en_a) begin
                    if (cnt_a < CNT_W'(N)) begin
                        wr_a_c    = 1'b1;
                        cnt_a_nxt = CNT_W'(cnt_a + CNT_W'(1));
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                if (fifo_wr_en_sub) begin
                    if (cnt_sub < CNT_W'(N)) begin
                        wr_sub_c    = 1'b1;
                        cnt_sub_nxt = CNT_W'(cnt_sub + CNT_W'(1));
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                if (cal_done) begin
                    if (done_l) begin
                        err_nxt = 1'b1;
                    end else begin
                        done_l_nxt = 1'b1;
                        sel_nxt    = cal_sign;
                    end
                end
                // Launch uses registered counts/flag only, so a same-cycle write never races it.
                if (done_l && full_c) begin
                    state_nxt = DRAIN;
                    valid_nxt = 1'b1;
                    idx_nxt   = '0;
                    data_nxt  = rd_word_c;
                end
            end

            DRAIN: begin
                if (fifo_wr_en_a || fifo_wr_en_sub || cal_done) begin
                    err_nxt = 1'b1;
                end
                if (o_valid && o_ready) begin
                    if (last_idx_c) begin
                        valid_nxt   = 1'b0;
                        cnt_a_nxt   = '0;
                        cnt_sub_nxt = '0;
                        done_l_nxt  = 1'b0;
                        state_nxt   = COLLECT;
                    end else begin
                        idx_nxt  = rd_idx_c;
                        data_nxt = rd_word_c;
                    end
                end
            end

            default: state_nxt = COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a     <= '0;
            cnt_sub   <= '0;
            done_l    <= 1'b0;
            err       <= 1'b0;
            o_sel_sub <= 1'b0;
            o_valid   <= 1'b0;
            o_idx     <= '0;
            o_data    <= '0;
        end else begin
            cnt_a     <= cnt_a_nxt;
            cnt_sub   <= cnt_sub_nxt;
            done_l    <= done_l_nxt;
            err       <= err_nxt;
            o_sel_sub <= sel_nxt;
            o_valid   <= valid_nxt;
            o_idx     <= idx_nxt;
            o_data    <= data_nxt;
        end
    end

    // Result storage; contents are don't-care until the matching count covers them.
    always_ff @(posedge clk) begin
        if (wr_a_c) begin
            buf_a[cnt_a[ADDR_W-1:0]] <= fifo_wr_data_a;
        end
        if (wr_sub_c) begin
            buf_sub[cnt_sub[ADDR_W-1:0]] <= fifo_wr_data_sub;
        end
    end

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Bench for iddmm_result_sel: directed operation table plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_iddmm_result_sel;

    localparam int unsigned K  = 128;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_wr_en_a = 1'b0;
    logic [K-1:0]  fifo_wr_data_a = '0;
    logic          fifo_wr_en_sub = 1'b0;
    logic [K-1:0]  fifo_wr_data_sub = '0;
    logic          cal_done = 1'b0;
    logic          cal_sign = 1'b0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [K-1:0]  o_data;
    logic [AW-1:0] o_idx;
    logic          o_last;
    logic          o_sel_sub;
    logic          busy;
    logic          err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    iddmm_result_sel #(.K(K), .N(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_wr_en_a     (fifo_wr_en_a),
        .fifo_wr_data_a   (fifo_wr_data_a),
        .fifo_wr_en_sub   (fifo_wr_en_sub),
        .fifo_wr_data_sub (fifo_wr_data_sub),
        .cal_done         (cal_done),
        .cal_sign         (cal_sign),
        .o_valid          (o_valid),
        .o_ready          (o_ready),
        .o_data           (o_data),
        .o_idx            (o_idx),
        .o_last           (o_last),
        .o_sel_sub        (o_sel_sub),
        .busy             (busy),
        .err              (err)
    );

    task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: each stream is a queue; a result is the selected queue read in order.
    logic [K-1:0] qa[$];
    logic [K-1:0] qs[$];
    bit           m_drain = 0;
    bit           m_done  = 0;
    bit           m_sel   = 0;
    bit           m_err   = 0;
    int           m_idx   = 0;
    logic [K-1:0] m_data  = '0;

    initial begin
        bit go;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                qa.delete();
                qs.delete();
                m_drain = 0; m_done = 0; m_sel = 0; m_err = 0;
                m_idx = 0; m_data = '0;
            end else begin
                go = !m_drain && m_done && qa.size() == N && qs.size() == N;
                if (!m_drain) begin
                    if (fifo_wr_en_a) begin
                        if (qa.size() < N) qa.push_back(fifo_wr_data_a);
                        else m_err = 1;
                    end
                    if (fifo_wr_en_sub) begin
                        if (qs.size() < N) qs.push_back(fifo_wr_data_sub);
                        else m_err = 1;
                    end
                    if (cal_done) begin
                        if (m_done) m_err = 1;
                        else begin
                            m_done = 1;
                            m_sel  = cal_sign;
                        end
                    end
                    if (go) begin
                        m_drain = 1;
                        m_idx   = 0;
                        m_data  = m_sel ? qs[0] : qa[0];
                    end
                end else begin
                    if (fifo_wr_en_a || fifo_wr_en_sub || cal_done) m_err = 1;
                    if (o_ready) begin
                        if (m_idx == N - 1) begin
                            m_drain = 0;
                            m_done  = 0;
                            qa.delete();
                            qs.delete();
                        end else begin
                            m_idx++;
                            m_data = m_sel ? qs[m_idx] : qa[m_idx];
                        end
                    end
                end
                #1;
                chk("m_valid", K'(o_valid), K'(m_drain));
                chk("m_data", o_data, m_data);
                chk("m_idx", K'(o_idx), K'(m_idx));
                chk("m_last", K'(o_last), K'(m_drain && m_idx == N - 1));
                chk("m_sel", K'(o_sel_sub), K'(m_sel));
                chk("m_busy", K'(busy), K'(m_done || m_drain));
                chk("m_err", K'(err), K'(m_err));
            end
        end
    end

    typedef struct {
        logic                  sign;
        logic [7:0]            rdy;
        int                    cd;
        int                    sd;
        logic                  extra;
        logic [K-1:0]          a0;
        logic [K-1:0]          s0;
        logic [N-1:0][K-1:0]   exp_w;
        logic                  exp_err;
    } rec_t;

    function automatic rec_t mk(input logic sign, input logic [7:0] rdy, input int cd,
                                input int sd, input logic extra, input logic [K-1:0] a0,
                                input logic [K-1:0] s0, input logic [K-1:0] e0,
                                input logic ee);
        rec_t r;
        r.sign = sign; r.rdy = rdy; r.cd = cd; r.sd = sd; r.extra = extra;
        r.a0 = a0; r.s0 = s0; r.exp_err = ee;
        for (int i = 0; i < N; i++) r.exp_w[i] = e0 + K'(i);
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        fifo_wr_en_a = 1'b0; fifo_wr_en_sub = 1'b0; cal_done = 1'b0;
    endtask

    // Raw words at cycles 0..3, sub words at sd..sd+3, cal_done at cd, optional protocol abuse after.
    task automatic write_op(input rec_t r);
        int last;
        last = 3;
        if (r.sd + 3 > last) last = r.sd + 3;
        if (r.cd > last) last = r.cd;
        for (int t = 0; t <= last + 1; t++) begin
            fifo_wr_en_a     = (t <= 3);
            fifo_wr_data_a   = r.a0 + K'(t);
            fifo_wr_en_sub   = (t >= r.sd) && (t <= r.sd + 3);
            fifo_wr_data_sub = r.s0 + K'(t - r.sd);
            cal_done         = (t == r.cd);
            cal_sign         = r.sign;
            if (t == last + 1 && r.extra) begin
                fifo_wr_en_a   = 1'b1;
                fifo_wr_data_a = K'(128'hEE);
                cal_done       = 1'b1;
                cal_sign       = ~r.sign;
            end
            o_ready = 1'b1;
            step();
            if (t == last) begin
                chk("lat_valid_low", K'(o_valid), K'(0));
                chk("lat_busy_high", K'(busy), K'(1));
            end
            if (t == last + 1) chk("lat_valid_high", K'(o_valid), K'(1));
        end
        idle_inputs();
    endtask

    task automatic drain(input rec_t r);
        int k;
        int c;
        k = 0;
        c = 0;
        while (k < N && c < 64) begin
            o_ready = r.rdy[c % 8];
            if (o_valid && o_ready) begin
                chk("drain_data", o_data, r.exp_w[k]);
                chk("drain_idx", K'(o_idx), K'(k));
                chk("drain_last", K'(o_last), K'(k == N - 1));
                chk("drain_sel", K'(o_sel_sub), K'(r.sign));
                k++;
            end
            step();
            c++;
        end
        if (k < N) chk("drain_timeout", K'(k), K'(N));
        o_ready = 1'b0;
        chk("post_busy", K'(busy), K'(0));
        chk("post_valid", K'(o_valid), K'(0));
        chk("post_err", K'(err), K'(r.exp_err));
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_valid"}, K'(o_valid), K'(0));
        chk({nm, "_data"}, o_data, K'(0));
        chk({nm, "_idx"}, K'(o_idx), K'(0));
        chk({nm, "_last"}, K'(o_last), K'(0));
        chk({nm, "_sel"}, K'(o_sel_sub), K'(0));
        chk({nm, "_busy"}, K'(busy), K'(0));
        chk({nm, "_err"}, K'(err), K'(0));
    endtask

    rec_t recs[5];

    initial begin
        rec_t r;
        int   c;

        recs[0] = mk(1'b1, 8'hFF, 3, 0, 1'b0, K'(128'h10), K'(128'h20), K'(128'h20), 1'b0);
        recs[1] = mk(1'b0, 8'h99, 3, 0, 1'b0, K'(128'h10), K'(128'h20), K'(128'h10), 1'b0);
        recs[2] = mk(1'b1, 8'hFF, 1, 1, 1'b0, K'(128'h10), K'(128'h20), K'(128'h20), 1'b0);
        recs[3] = mk(1'b0, 8'hFF, 3, 0, 1'b1, K'(128'h10), K'(128'h20), K'(128'h10), 1'b1);
        recs[4] = mk(1'b1, 8'h6D, 3, 0, 1'b0, K'(128'h30), K'(128'h40), K'(128'h40), 1'b1);

        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Consecutive records run back to back: each starts the cycle busy falls.
        for (int i = 0; i < 5; i++) begin
            write_op(recs[i]);
            drain(recs[i]);
        end

        // Asynchronous reset in the middle of a drain.
        r = mk(1'b1, 8'hFF, 3, 0, 1'b0, K'(128'h50), K'(128'h60), K'(128'h60), 1'b1);
        write_op(r);
        c = 0;
        while (!(o_valid && o_idx == AW'(2)) && c < 16) begin
            o_ready = 1'b1;
            step();
            c++;
        end
        chk("reach_idx2", K'(o_idx), K'(2));
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        o_ready = 1'b0;
        step();
        r = mk(1'b0, 8'hFF, 3, 0, 1'b0, K'(128'h70), K'(128'h80), K'(128'h70), 1'b0);
        write_op(r);
        drain(r);

        // Randomized traffic, including protocol abuse, with periodic resets.
        for (int i = 0; i < 1500; i++) begin
            fifo_wr_en_a     = ($urandom_range(0, 3) != 0);
            fifo_wr_data_a   = {$urandom(), $urandom(), $urandom(), $urandom()};
            fifo_wr_en_sub   = ($urandom_range(0, 3) != 0);
            fifo_wr_data_sub = {$urandom(), $urandom(), $urandom(), $urandom()};
            cal_done         = ($urandom_range(0, 7) == 0);
            cal_sign         = 1'($urandom_range(0, 1));
            o_ready          = ($urandom_range(0, 2) != 0);
            if (i % 300 == 299) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        idle_inputs();
        o_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/iddmm_result_sel.md
# iddmm_result_sel

Final-result selector and output buffer placed directly downstream of the IDDMM calculation stage. Captures the two candidate result streams the calculation stage writes word by word: the raw accumulator `a` and the conditionally reduced `a - p`. On the calculation-done strobe it latches the select sign. Once both candidates are complete, it streams the chosen N-word result out over a valid/ready interface, least-significant word first, and signals when it can accept the next operation.

## Interface
Parameters:
- `K`, 128, bits per word
- `N`, 32, words per operand
- `ADDR_W`, `$clog2(N)`, word index width

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fifo_wr_en_a` in 1: write strobe, raw-result word.
- `fifo_wr_data_a` in K: raw-result word, LSW first.
- `fifo_wr_en_sub` in 1: write strobe, subtracted-result word.
- `fifo_wr_data_sub` in K: subtracted-result word, LSW first.
- `cal_done` in 1: one-cycle strobe, calculation finished.
- `cal_sign` in 1: valid with `cal_done`; 1 = output the sub stream, 0 = output the raw stream.
- `o_valid` out 1: output word valid.
- `o_ready` in 1: downstream accepts the word.
- `o_data` out K: selected result word.
- `o_idx` out ADDR_W: index of `o_data` (0 = LSW).
- `o_last` out 1: `o_valid` && `o_idx == N-1`.
- `o_sel_sub` out 1: latched `cal_sign` for the current result.
- `busy` out 1: high from the `cal_done` latch until the last word is accepted. The controller must not launch a new operation while it is high.
- `err` out 1: sticky protocol-error flag; cleared only by reset.

## Operation
- Storage: two N×K buffers, `buf_a` and `buf_sub`, each with a write counter (`cnt_a`, `cnt_sub`, range 0..N, width ADDR_W+1).
- State machine: COLLECT, DRAIN.
- COLLECT behaviour:
  - A write strobe with count < N stores the word at index = count; the count increments.
  - A write strobe with count == N drops the word and sets `err`.
  - `cal_done` sets `done_l` and latches `cal_sign` into `o_sel_sub`.
  - `cal_done` while `done_l` is already set: ignored (sign unchanged), sets `err`.
  - `cal_done` and a write in the same cycle are both accepted.
- COLLECT→DRAIN: evaluated on registered values. Condition is `done_l && cnt_a == N && cnt_sub == N`. At that edge:
  - state <= DRAIN
  - `o_valid` <= 1
  - `o_idx` <= 0
  - `o_data` <= word 0 of the selected buffer
- DRAIN behaviour:
  - Each edge with `o_valid && o_ready` and `o_idx < N-1`: `o_idx` increments and `o_data` loads the next word.
  - With `o_idx == N-1`: `o_valid` <= 0; `cnt_a`, `cnt_sub`, `done_l` are cleared; state <= COLLECT.
- Backpressure: with `o_valid` high and `o_ready` low, `o_data`, `o_idx`, `o_last` hold.
- Errors in DRAIN: any write strobe or `cal_done` is dropped and sets `err`.
- Selection is applied on read only; both buffers are always filled. The unselected stream is discarded.
- `busy` = `done_l` || state == DRAIN.

## Timing
- Reset (asynchronous, any state including mid-drain):
  - state = COLLECT
  - all counters = 0
  - `done_l` = 0
  - `o_valid` = 0, `o_data` = 0, `o_idx` = 0, `o_last` = 0
  - `o_sel_sub` = 0, `busy` = 0, `err` = 0
- Latency: if both buffers are full by the `cal_done` cycle C:
  - `done_l` and `busy` are high from C+1.
  - `o_valid` is high from C+2 with word 0.
- If the last write arrives after `cal_done` at cycle W, `o_valid` rises at W+2.
- Throughput: with `o_ready` held high, one word per cycle. The N words occupy N consecutive cycles; `busy` falls the cycle after the `o_last` handshake.
- A new write to COLLECT is accepted in the same cycle `busy` falls.
- `o_ready` may be high while `o_valid` is low; this has no effect.
- All outputs are registered, except `o_last` and `busy`, which are decoded from registers only.

## Test plan
- N=4, K=128. Raw stream = 0x10..0x13, sub stream = 0x20..0x23. `cal_done` with sign=1 in the same cycle as the last writes, `o_ready`=1. Required: `o_valid` at C+2; `o_data` = 0x20, 0x21, 0x22, 0x23 on consecutive cycles; `o_last` on 0x23; `busy` low the cycle after.
- Same streams, sign=0. `o_ready` toggles 1,0,0,1,... Required: `o_data` = 0x10..0x13 in order; each word held stable while `o_ready`=0; no word skipped or duplicated.
- `cal_done` arrives 3 cycles before the final sub write. Required: `o_valid` rises exactly 2 cycles after that final write; `err` stays 0.
- 5th raw write while `cnt_a` == 4, plus a second `cal_done`. Required: `err` = 1 (sticky); output is still the original 4 words; the second sign is ignored.
- Back-to-back operations: a second full operation is written starting in the cycle `busy` falls. Required: the second result streams correctly with its own sign.
- Reset asserted asynchronously mid-drain at `o_idx` = 2. Required: all outputs 0 immediately. A following fresh operation then outputs from word 0.
